wbm_regs_mc: RTL and testbench

//  Parametrised Wishbone slave register file for the multi-channel scatter/gather DMA engine.

---
 rtl/wbm_regs_mc.sv | 242 ++++++++++++++++++++++++
 tb/tb_wbm_regs_mc.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbm_regs_mc.sv
`default_nettype none
// ============================================================================
// Module   : wbm_regs_mc
// Purpose  : Wishbone slave register file for the multi-channel scatter/gather
//            DMA engine. Window 0 holds the global ID/GISR/GCTL registers.
//            Window c+1 holds channel c's CCR/CSR/DAR/NDAR/ISR/IMR. ISR bits
//            latch engine events, IMR masks them, and a registered combined
//            IRQ is produced. Every access gets exactly one registered ACK or
//            ERR pulse.
// Ports    : wb_clk_i/wb_rst_i        clock, async active-high reset
//            wbs_*                    Wishbone classic slave port
//            dar_i/csr_i              per-channel engine status (read only)
//            busy_i/ch_done_i/ch_err_i per-channel engine state and events
//            *_clear_i                engine-side clears of control bits
//            ndar_o/ndar_dirty_o      next descriptor address and dirty flag
//            resume_o/enable_o/int_ack_o per-channel control bits
//            wb_irq_o                 combined, registered interrupt
// Revision : 1.0 - initial release
// ============================================================================
module wbm_regs_mc #(
  parameter int          NCH = 4,
  parameter int          AW  = 8,
  parameter logic [15:0] ID  = 16'hD3A1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic              wbs_err_o,
  output logic              wbs_rty_o,
  input  logic [32*NCH-1:0] dar_i,
  input  logic [8*NCH-1:0]  csr_i,
  input  logic [NCH-1:0]    busy_i,
  input  logic [NCH-1:0]    ch_done_i,
  input  logic [NCH-1:0]    ch_err_i,
  input  logic [NCH-1:0]    ndar_dirty_clear_i,
  input  logic [NCH-1:0]    resume_clear_i,
  input  logic [NCH-1:0]    int_ack_clear_i,
  output logic [29*NCH-1:0] ndar_o,
  output logic [NCH-1:0]    ndar_dirty_o,
  output logic [NCH-1:0]    resume_o,
  output logic [NCH-1:0]    enable_o,
  output logic [NCH-1:0]    int_ack_o,
  output logic              wb_irq_o
);

  // Word offsets inside a window
  localparam logic [2:0] OFF_ID   = 3'd0;
  localparam logic [2:0] OFF_GISR = 3'd1;
  localparam logic [2:0] OFF_GCTL = 3'd2;
  localparam logic [2:0] OFF_CCR  = 3'd0;
  localparam logic [2:0] OFF_CSR  = 3'd1;
  localparam logic [2:0] OFF_DAR  = 3'd2;
  localparam logic [2:0] OFF_NDAR = 3'd3;
  localparam logic [2:0] OFF_ISR  = 3'd4;
  localparam logic [2:0] OFF_IMR  = 3'd5;

  // Registered state
  logic [31:0]       dat_q, dat_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              irq_q, irq_d;
  logic              irq_en_q, irq_en_d;
  logic [NCH-1:0]    resume_q, resume_d;
  logic [NCH-1:0]    enable_q, enable_d;
  logic [NCH-1:0]    int_ack_q, int_ack_d;
  logic [29*NCH-1:0] ndar_q, ndar_d;
  logic [NCH-1:0]    ndar_dirty_q, ndar_dirty_d;
  logic [NCH-1:0]    isr_done_q, isr_done_d;
  logic [NCH-1:0]    isr_err_q, isr_err_d;
  logic [NCH-1:0]    imr_done_q, imr_done_d;
  logic [NCH-1:0]    imr_err_q, imr_err_d;
  logic [NCH-1:0]    done_prev_q, done_prev_d;

  // Decode
  logic [31:0]    win_idx;
  logic [2:0]     off;
  logic           req, glb, ro_hit, bad, wr_en;
  logic [NCH-1:0] ch_wr;
  logic [NCH-1:0] irq_vec;
  logic [31:0]    rd_data;
  logic           unused_adr;

  assign win_idx    = 32'(wbs_adr_i[AW-1:5]);
  assign off        = wbs_adr_i[4:2];
  assign unused_adr = ^{wbs_adr_i[31:AW], wbs_adr_i[1:0]};

  // Per-channel pending interrupt, also the GISR bit
  assign irq_vec = (isr_done_q & imr_done_q) | (isr_err_q & imr_err_q);

  // The ~ack/~err terms keep a held strobe from issuing a second response
  // in the cycle the first one is visible.
  always_comb begin
    req    = wbs_cyc_i & wbs_stb_i & ~ack_q & ~err_q;
    glb    = (win_idx == 32'd0);
    ro_hit = glb ? (off == OFF_ID || off == OFF_GISR)
                 : (off == OFF_CSR || off == OFF_DAR);
    bad    = (wbs_sel_i != 4'hF) | (win_idx > 32'(NCH)) | (wbs_we_i & ro_hit);
    wr_en  = req & wbs_we_i & ~bad;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch_sel
    assign ch_wr[c] = wr_en & (win_idx == 32'(c + 1));
  end

  // Read mux; unmapped offsets read as zero
  always_comb begin
    rd_data = 32'd0;
    if (glb) begin
      case (off)
        OFF_ID:   rd_data = {ID, 8'(NCH), 8'h02};
        OFF_GISR: rd_data = 32'(irq_vec);
        OFF_GCTL: rd_data = {31'd0, irq_en_q};
        default:  rd_data = 32'd0;
      endcase
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (win_idx == 32'(c) + 32'd1) begin
          case (off)
            OFF_CCR:  rd_data = {29'd0, int_ack_q[c], enable_q[c], resume_q[c]};
            OFF_CSR:  rd_data = {16'd0, csr_i[8*c +: 8], 6'd0, busy_i[c], irq_vec[c]};
            OFF_DAR:  rd_data = dar_i[32*c +: 32];
            OFF_NDAR: rd_data = {ndar_q[29*c +: 29], 2'd0, ndar_dirty_q[c]};
            OFF_ISR:  rd_data = {30'd0, isr_err_q[c], isr_done_q[c]};
            OFF_IMR:  rd_data = {30'd0, imr_err_q[c], imr_done_q[c]};
            default:  rd_data = 32'd0;
          endcase
        end
      end
    end
  end

  // Next state. Bus writes override engine clears; engine event sets
  // override a same-cycle W1C.
  always_comb begin
    ack_d        = req & ~bad;
    err_d        = req & bad;
    dat_d        = (req & ~bad) ? rd_data : dat_q;
    irq_d        = irq_en_q & (|irq_vec);
    irq_en_d     = irq_en_q;
    resume_d     = resume_q;
    enable_d     = enable_q;
    int_ack_d    = int_ack_q;
    ndar_d       = ndar_q;
    ndar_dirty_d = ndar_dirty_q;
    isr_done_d   = isr_done_q;
    isr_err_d    = isr_err_q;
    imr_done_d   = imr_done_q;
    imr_err_d    = imr_err_q;
    done_prev_d  = ch_done_i;

    if (wr_en && glb && off == OFF_GCTL) begin
      irq_en_d = wbs_dat_i[0];
    end

    for (int c = 0; c < NCH; c++) begin
      if (ch_wr[c] && off == OFF_CCR) begin
        resume_d[c]  = wbs_dat_i[0];
        enable_d[c]  = wbs_dat_i[1];
        int_ack_d[c] = wbs_dat_i[2];
      end else begin
        if (resume_clear_i[c])  resume_d[c]  = 1'b0;
        if (int_ack_clear_i[c]) int_ack_d[c] = 1'b0;
      end

      if (ch_wr[c] && off == OFF_NDAR) begin
        ndar_d[29*c +: 29] = wbs_dat_i[31:3];
        ndar_dirty_d[c]    = 1'b1;
      end else if (ndar_dirty_clear_i[c]) begin
        ndar_dirty_d[c] = 1'b0;
      end

      if (ch_wr[c] && off == OFF_ISR) begin
        isr_done_d[c] = isr_done_q[c] & ~wbs_dat_i[0];
        isr_err_d[c]  = isr_err_q[c] & ~wbs_dat_i[1];
      end
      // done latches on the rising edge of the level, err on the pulse
      if (ch_done_i[c] && !done_prev_q[c]) isr_done_d[c] = 1'b1;
      if (ch_err_i[c])                     isr_err_d[c]  = 1'b1;

      if (ch_wr[c] && off == OFF_IMR) begin
        imr_done_d[c] = wbs_dat_i[0];
        imr_err_d[c]  = wbs_dat_i[1];
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      dat_q        <= 32'd0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      irq_q        <= 1'b0;
      irq_en_q     <= 1'b0;
      resume_q     <= '0;
      enable_q     <= '0;
      int_ack_q    <= '0;
      ndar_q       <= '0;
      ndar_dirty_q <= '0;
      isr_done_q   <= '0;
      isr_err_q    <= '0;
      imr_done_q   <= '0;
      imr_err_q    <= '0;
      done_prev_q  <= '0;
    end else begin
      dat_q        <= dat_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      irq_q        <= irq_d;
      irq_en_q     <= irq_en_d;
      resume_q     <= resume_d;
      enable_q     <= enable_d;
      int_ack_q    <= int_ack_d;
      ndar_q       <= ndar_d;
      ndar_dirty_q <= ndar_dirty_d;
      isr_done_q   <= isr_done_d;
      isr_err_q    <= isr_err_d;
      imr_done_q   <= imr_done_d;
      imr_err_q    <= imr_err_d;
      done_prev_q  <= done_prev_d;
    end
  end

  assign wbs_dat_o    = dat_q;
  assign wbs_ack_o    = ack_q;
  assign wbs_err_o    = err_q;
  assign wbs_rty_o    = 1'b0;
  assign ndar_o       = ndar_q;
  assign ndar_dirty_o = ndar_dirty_q;
  assign resume_o     = resume_q;
  assign enable_o     = enable_q;
  assign int_ack_o    = int_ack_q;
  assign wb_irq_o     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_wbm_regs_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_wbm_regs_mc
// Purpose  : Self-checking bench for wbm_regs_mc using a register-level model
//            of the address map, interrupt latching and priority rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wbm_regs_mc;
  localparam int NCH = 4;
  localparam logic [NCH-1:0] Z = '0;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i = 1'b1;
  logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]        sel = 4'h0;
  logic [31:0]       adr = 32'd0, wdat = 32'd0;
  logic [31:0]       wbs_dat_o;
  logic              wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic [32*NCH-1:0] dar_i = '0;
  logic [8*NCH-1:0]  csr_i = '0;
  logic [NCH-1:0]    busy_i = '0, ch_done_i = '0, ch_err_i = '0;
  logic [NCH-1:0]    ndc_i = '0, rc_i = '0, iac_i = '0;
  logic [29*NCH-1:0] ndar_o;
  logic [NCH-1:0]    ndar_dirty_o, resume_o, enable_o, int_ack_o;
  logic              wb_irq_o;

  int tests = 0;
  int fails = 0;
  int ack_cnt = 0;

  // Reference model state
  logic [2:0]  m_ccr  [NCH];
  logic [28:0] m_ndar [NCH];
  logic        m_dirty[NCH];
  logic [1:0]  m_isr  [NCH];
  logic [1:0]  m_imr  [NCH];
  logic        m_irq_en;

  wbm_regs_mc #(.NCH(NCH), .AW(8), .ID(16'hD3A1)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(wbs_dat_o),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
    .dar_i(dar_i), .csr_i(csr_i), .busy_i(busy_i),
    .ch_done_i(ch_done_i), .ch_err_i(ch_err_i),
    .ndar_dirty_clear_i(ndc_i), .resume_clear_i(rc_i), .int_ack_clear_i(iac_i),
    .ndar_o(ndar_o), .ndar_dirty_o(ndar_dirty_o), .resume_o(resume_o),
    .enable_o(enable_o), .int_ack_o(int_ack_o), .wb_irq_o(wb_irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(negedge wb_clk_i) if (wbs_ack_o === 1'b1) ack_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_ccr[c] = 3'd0; m_ndar[c] = 29'd0; m_dirty[c] = 1'b0;
      m_isr[c] = 2'd0; m_imr[c] = 2'd0;
    end
    m_irq_en = 1'b0;
  endtask

  function automatic logic [NCH-1:0] m_gisr();
    logic [NCH-1:0] g = '0;
    for (int c = 0; c < NCH; c++) g[c] = |(m_isr[c] & m_imr[c]);
    return g;
  endfunction

  function automatic logic exp_bad(input logic w_en, input logic [31:0] a, input logic [3:0] s);
    int w = int'(a[7:5]);
    int o = int'(a[4:2]);
    if (s != 4'hF) return 1'b1;
    if (w > NCH) return 1'b1;
    if (w_en && w == 0 && o <= 1) return 1'b1;
    if (w_en && w != 0 && (o == 1 || o == 2)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int w = int'(a[7:5]);
    int o = int'(a[4:2]);
    int c = w - 1;
    logic [31:0] r = 32'd0;
    logic [NCH-1:0] g = m_gisr();
    if (w == 0) begin
      if (o == 0) r = {16'hD3A1, 8'(NCH), 8'h02};
      else if (o == 1) r = 32'(g);
      else if (o == 2) r = {31'd0, m_irq_en};
    end else if (w <= NCH) begin
      case (o)
        0: r = 32'(m_ccr[c]);
        1: r = {16'd0, csr_i[8*c +: 8], 6'd0, busy_i[c], g[c]};
        2: r = dar_i[32*c +: 32];
        3: r = {m_ndar[c], 2'b00, m_dirty[c]};
        4: r = 32'(m_isr[c]);
        5: r = 32'(m_imr[c]);
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  // Apply one clock edge's worth of rules: clears, then a bus write, then event sets
  task automatic model_step(input logic w_en, input logic ok, input logic [31:0] a,
                            input logic [31:0] d, input logic [NCH-1:0] errp,
                            input logic [NCH-1:0] ndc, input logic [NCH-1:0] rc,
                            input logic [NCH-1:0] iac, input logic [NCH-1:0] donep);
    int w = int'(a[7:5]);
    int o = int'(a[4:2]);
    for (int c = 0; c < NCH; c++) begin
      if (ndc[c]) m_dirty[c] = 1'b0;
      if (rc[c])  m_ccr[c][0] = 1'b0;
      if (iac[c]) m_ccr[c][2] = 1'b0;
    end
    if (w_en && ok) begin
      if (w == 0 && o == 2) m_irq_en = d[0];
      else if (w >= 1) begin
        case (o)
          0: m_ccr[w-1] = d[2:0];
          3: begin m_ndar[w-1] = d[31:3]; m_dirty[w-1] = 1'b1; end
          4: m_isr[w-1] = m_isr[w-1] & ~d[1:0];
          5: m_imr[w-1] = d[1:0];
          default: ;
        endcase
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (errp[c])  m_isr[c][1] = 1'b1;
      if (donep[c]) m_isr[c][0] = 1'b1;
    end
  endtask

  task automatic chk_outputs(input string tag);
    logic [NCH-1:0] e_dirty, e_res, e_en, e_iac;
    for (int c = 0; c < NCH; c++) begin
      chk({tag, " ndar"}, 32'(ndar_o[29*c +: 29]), 32'(m_ndar[c]));
      e_dirty[c] = m_dirty[c]; e_res[c] = m_ccr[c][0];
      e_en[c] = m_ccr[c][1];   e_iac[c] = m_ccr[c][2];
    end
    chk({tag, " dirty"},   32'(ndar_dirty_o), 32'(e_dirty));
    chk({tag, " resume"},  32'(resume_o),     32'(e_res));
    chk({tag, " enable"},  32'(enable_o),     32'(e_en));
    chk({tag, " int_ack"}, 32'(int_ack_o),    32'(e_iac));
    chk({tag, " irq"},     32'(wb_irq_o),     32'(m_irq_en & (|m_gisr())));
    chk({tag, " rty"},     32'(wbs_rty_o),    32'd0);
  endtask

  task automatic wb_acc(input logic w_en, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [NCH-1:0] errp,
                        input logic [NCH-1:0] ndc, input logic [NCH-1:0] rc,
                        input logic [NCH-1:0] iac, output logic [31:0] rd,
                        output logic got_ack, output logic got_err);
    @(posedge wb_clk_i); #1;
    cyc = 1'b1; stb = 1'b1; we = w_en; adr = a; wdat = d; sel = s;
    ch_err_i = errp; ndc_i = ndc; rc_i = rc; iac_i = iac;
    got_ack = 1'b0; got_err = 1'b0;
    for (int i = 0; i < 4 && !got_ack && !got_err; i++) begin
      @(posedge wb_clk_i); #1;
      got_ack = wbs_ack_o; got_err = wbs_err_o;
      ch_err_i = '0; ndc_i = '0; rc_i = '0; iac_i = '0;
    end
    rd = wbs_dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic do_acc(input string tag, input logic w_en, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [NCH-1:0] errp, input logic [NCH-1:0] ndc,
                        input logic [NCH-1:0] rc, input logic [NCH-1:0] iac,
                        output logic [31:0] rd);
    logic b, ga, ge;
    logic [31:0] er;
    b  = exp_bad(w_en, a, s);
    er = exp_read(a);
    wb_acc(w_en, a, d, s, errp, ndc, rc, iac, rd, ga, ge);
    chk({tag, " ack"}, 32'(ga), 32'(!b));
    chk({tag, " err"}, 32'(ge), 32'(b));
    if (!w_en && !b) chk({tag, " rdata"}, rd, er);
    model_step(w_en, !b, a, d, errp, ndc, rc, iac, Z);
    @(posedge wb_clk_i); #1;
    chk_outputs(tag);
  endtask

  task automatic engine_pulse(input string tag, input logic [NCH-1:0] donep,
                              input logic [NCH-1:0] errp, input logic [NCH-1:0] ndc,
                              input logic [NCH-1:0] rc, input logic [NCH-1:0] iac);
    @(posedge wb_clk_i); #1;
    ch_done_i = donep; ch_err_i = errp; ndc_i = ndc; rc_i = rc; iac_i = iac;
    @(posedge wb_clk_i); #1;
    ch_done_i = '0; ch_err_i = '0; ndc_i = '0; rc_i = '0; iac_i = '0;
    model_step(1'b0, 1'b0, 32'd0, 32'd0, errp, ndc, rc, iac, donep);
    @(posedge wb_clk_i); #1;
    chk_outputs(tag);
  endtask

  function automatic logic [NCH-1:0] rmask();
    logic [31:0] r = $urandom;
    return ($urandom_range(0, 3) == 0) ? r[NCH-1:0] : '0;
  endfunction

  initial begin
    logic [31:0] rd, r;
    int a0;
    model_reset();
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;

    // Reset state
    chk("reset dat_o", wbs_dat_o, 32'd0);
    chk("reset ack", 32'(wbs_ack_o), 32'd0);
    chk_outputs("reset");

    // ID read and single-pulse ACK
    do_acc("id read", 1'b0, 32'h0, 32'h0, 4'hF, Z, Z, Z, Z, rd);
    chk("id value", rd, 32'hD3A1_0402);
    a0 = ack_cnt;
    @(posedge wb_clk_i); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF;
    @(posedge wb_clk_i); #1;
    chk("ack after req", 32'(wbs_ack_o), 32'd1);
    @(posedge wb_clk_i); #1;
    chk("ack second cycle", 32'(wbs_ack_o), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge wb_clk_i); #1;
    chk("single ack", 32'(ack_cnt - a0), 32'd1);

    // NDAR write, dirty flag and clear priority
    do_acc("ndar wr", 1'b1, 32'h6C, 32'h1234_5678, 4'hF, Z, Z, Z, Z, rd);
    chk("ndar ch2 value", 32'(ndar_o[58 +: 29]), 32'h0246_8ACF);
    chk("ndar ch2 dirty", 32'(ndar_dirty_o[2]), 32'd1);
    do_acc("ndar rewrite+clr", 1'b1, 32'h6C, 32'hCAFE_0008, 4'hF, Z, 4'b0100, Z, Z, rd);
    chk("dirty wins clear", 32'(ndar_dirty_o[2]), 32'd1);
    engine_pulse("dirty clr", Z, Z, 4'b0100, Z, Z);
    chk("dirty cleared", 32'(ndar_dirty_o[2]), 32'd0);

    // Interrupt path on channel 0
    do_acc("imr0", 1'b1, 32'h34, 32'h1, 4'hF, Z, Z, Z, Z, rd);
    do_acc("gctl", 1'b1, 32'h08, 32'h1, 4'hF, Z, Z, Z, Z, rd);
    @(posedge wb_clk_i); #1;
    ch_done_i = 4'b0001;
    @(posedge wb_clk_i); #1;
    ch_done_i = '0;
    model_step(1'b0, 1'b0, 32'd0, 32'd0, Z, Z, Z, Z, 4'b0001);
    chk("irq latency", 32'(wb_irq_o), 32'd0);
    @(posedge wb_clk_i); #1;
    chk("irq raised", 32'(wb_irq_o), 32'd1);
    do_acc("isr0 rd", 1'b0, 32'h30, 32'h0, 4'hF, Z, Z, Z, Z, rd);
    chk("isr0 done", rd, 32'h1);
    do_acc("isr0 w1c", 1'b1, 32'h30, 32'h1, 4'hF, Z, Z, Z, Z, rd);
    chk("irq dropped", 32'(wb_irq_o), 32'd0);
    engine_pulse("err0", Z, 4'b0001, Z, Z, Z);
    do_acc("w1c vs err", 1'b1, 32'h30, 32'h3, 4'hF, 4'b0001, Z, Z, Z, rd);
    do_acc("isr0 rd2", 1'b0, 32'h30, 32'h0, 4'hF, Z, Z, Z, Z, rd);
    chk("err survives w1c", rd, 32'h2);

    // Error responses leave state untouched
    do_acc("sel3 rd", 1'b0, 32'h00, 32'h0, 4'h3, Z, Z, Z, Z, rd);
    do_acc("dar wr", 1'b1, 32'h28, 32'hFFFF_FFFF, 4'hF, Z, Z, Z, Z, rd);
    do_acc("win5 rd", 1'b0, 32'hA0, 32'h0, 4'hF, Z, Z, Z, Z, rd);
    do_acc("gisr wr", 1'b1, 32'h04, 32'hF, 4'hF, Z, Z, Z, Z, rd);

    // CCR write then engine resume clear
    do_acc("ccr1 wr", 1'b1, 32'h40, 32'h5, 4'hF, Z, Z, Z, Z, rd);
    chk("ccr1 resume", 32'(resume_o[1]), 32'd1);
    chk("ccr1 int_ack", 32'(int_ack_o[1]), 32'd1);
    engine_pulse("resume clr", Z, Z, Z, 4'b0010, Z);
    chk("resume cleared", 32'(resume_o[1]), 32'd0);
    chk("int_ack held", 32'(int_ack_o[1]), 32'd1);

    // done is edge-triggered: a held level does not re-latch after W1C
    @(posedge wb_clk_i); #1;
    ch_done_i = 4'b1000;
    @(posedge wb_clk_i); #1;
    model_step(1'b0, 1'b0, 32'd0, 32'd0, Z, Z, Z, Z, 4'b1000);
    do_acc("isr3 w1c", 1'b1, 32'h90, 32'h1, 4'hF, Z, Z, Z, Z, rd);
    do_acc("isr3 rd", 1'b0, 32'h90, 32'h0, 4'hF, Z, Z, Z, Z, rd);
    chk("isr3 level no relatch", rd, 32'h0);
    ch_done_i = '0;

    // Randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      busy_i = 4'($urandom);
      csr_i  = $urandom;
      for (int c = 0; c < NCH; c++) dar_i[32*c +: 32] = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        engine_pulse("rnd evt", rmask(), rmask(), rmask(), rmask(), rmask());
      end else begin
        r = $urandom;
        adr = {r[31:8], 3'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), r[1:0]};
        r = $urandom;
        do_acc("rnd acc", 1'($urandom), adr, $urandom,
               ($urandom_range(0, 7) == 0) ? r[3:0] : 4'hF,
               rmask(), rmask(), rmask(), rmask(), rd);
      end
    end

    // Reset during a pending access: no ACK and everything cleared
    do_acc("pre-rst rd", 1'b0, 32'h00, 32'h0, 4'hF, Z, Z, Z, Z, rd);
    a0 = ack_cnt;
    @(posedge wb_clk_i); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF;
    #2 wb_rst_i = 1'b1;
    @(posedge wb_clk_i); @(posedge wb_clk_i); #1;
    cyc = 1'b0; stb = 1'b0;
    model_reset();
    chk("rst no ack", 32'(ack_cnt - a0), 32'd0);
    chk("rst dat_o", wbs_dat_o, 32'd0);
    chk_outputs("rst pending");
    wb_rst_i = 1'b0;

    // Reset while ACK is high drops it without waiting for a clock
    @(posedge wb_clk_i); #1;
    cyc = 1'b1; stb = 1'b1; adr = 32'h0; sel = 4'hF;
    @(posedge wb_clk_i); #1;
    chk("ack before rst", 32'(wbs_ack_o), 32'd1);
    wb_rst_i = 1'b1;
    #1;
    chk("async ack drop", 32'(wbs_ack_o), 32'd0);
    chk("async dat clear", wbs_dat_o, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
